// File: rtl/weight_pkg.sv
// Shared types and the saturating gradient-step helper for the weight bank.
// Weights are signed two's complement, Q8.8 by default.
package weight_pkg;

    localparam int DATA_W = 16;

    typedef logic signed [DATA_W-1:0] weight_t;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } bank_state_e;

    typedef struct packed {
        logic    sat;
        weight_t val;
    } sat_res_t;

    // w - (g >>> sh), computed one bit wider and clamped to the weight range
    function automatic sat_res_t sat_sub_shift(
        input weight_t     w,
        input weight_t     g,
        input int unsigned sh
    );
        logic signed [DATA_W:0] d;
        weight_t                gs;
        sat_res_t               r;
        gs    = g >>> sh;
        d     = {w[DATA_W-1], w} - {gs[DATA_W-1], gs};
        r.sat = d[DATA_W] ^ d[DATA_W-1];
        if (!r.sat) begin
            r.val = d[DATA_W-1:0];
        end else if (d[DATA_W]) begin
            r.val = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            r.val = {1'b0, {(DATA_W-1){1'b1}}};
        end
        return r;
    endfunction

endpackage

// File: rtl/weight_update_alu.sv
// Combinational row update: COLS parallel saturating gradient-step lanes.
// Column 0 lives in the most-significant slice of each row vector.
module weight_update_alu
    import weight_pkg::*;
#(
    parameter int          COLS     = 3,
    parameter int unsigned LR_SHIFT = 0
) (
    input  logic [DATA_W*COLS-1:0] row_i,
    input  logic [DATA_W*COLS-1:0] grad_i,
    output logic [DATA_W*COLS-1:0] row_o,
    output logic [COLS-1:0]        sat_o
);

    for (genvar c = 0; c < COLS; c++) begin : g_lane
        localparam int LSB = (COLS - 1 - c) * DATA_W;
        sat_res_t r;
        assign r = sat_sub_shift(
            weight_t'(row_i[LSB +: DATA_W]),
            weight_t'(grad_i[LSB +: DATA_W]),
            LR_SHIFT
        );
        assign row_o[LSB +: DATA_W] = r.val;
        assign sat_o[c]             = r.sat;
    end

endmodule

// File: rtl/weight_bank.sv
// LAYERS x ROWS x COLS weight store: registered row reads, host writes,
// saturating gradient updates and a one-row-per-cycle zeroing sweep.
module weight_bank
    import weight_pkg::*;
#(
    parameter int          COLS     = 3,
    parameter int          ROWS     = 3,
    parameter int          LAYERS   = 5,
    parameter int unsigned LR_SHIFT = 0,
    parameter int          SATCNT_W = 16,
    localparam int         LW       = $clog2(LAYERS),
    localparam int         RW       = $clog2(ROWS),
    localparam int         ROW_W    = DATA_W * COLS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear_req,
    output logic                busy,
    input  logic                upd_valid,
    output logic                upd_ready,
    input  logic [LW-1:0]       upd_layer,
    input  logic [RW-1:0]       upd_row,
    input  logic [ROW_W-1:0]    upd_grad,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [LW-1:0]       wr_layer,
    input  logic [RW-1:0]       wr_row,
    input  logic [ROW_W-1:0]    wr_data,
    input  logic                rd_en,
    input  logic [LW-1:0]       rd_layer,
    input  logic [RW-1:0]       rd_row,
    output logic [ROW_W-1:0]    rd_data,
    output logic                rd_valid,
    output logic [SATCNT_W-1:0] sat_count,
    output logic                err_oob
);

    localparam int DEPTH = LAYERS * ROWS;
    localparam int AW    = $clog2(DEPTH);

    function automatic logic [AW-1:0] addr_of(
        input logic [LW-1:0] l,
        input logic [RW-1:0] r
    );
        return AW'(32'(l) * ROWS + 32'(r));
    endfunction

    function automatic logic in_range(
        input logic [LW-1:0] l,
        input logic [RW-1:0] r
    );
        return (32'(l) < LAYERS) && (32'(r) < ROWS);
    endfunction

    bank_state_e state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;

    logic [ROW_W-1:0] mem_q [DEPTH];

    logic [ROW_W-1:0]    rd_data_q;
    logic                rd_valid_q;
    logic [SATCNT_W-1:0] sat_q, sat_d;
    logic                err_q, err_d;

    logic          wr_fire, upd_fire, rd_fire;
    logic          wr_inr, upd_inr, rd_inr;
    logic          wr_ok, upd_commit;
    logic [AW-1:0] wr_addr, upd_addr, rd_addr;

    logic [ROW_W-1:0] upd_cur, upd_new, rd_word;
    logic [COLS-1:0]  upd_sat;

    logic [SATCNT_W:0] sat_add, sat_sum;

    assign busy      = (state_q == CLEAR);
    assign upd_ready = !busy;
    assign wr_ready  = !busy;

    assign wr_fire  = wr_valid && wr_ready;
    assign upd_fire = upd_valid && upd_ready;
    assign rd_fire  = rd_en && !busy;

    assign wr_inr  = in_range(wr_layer, wr_row);
    assign upd_inr = in_range(upd_layer, upd_row);
    assign rd_inr  = in_range(rd_layer, rd_row);

    assign wr_addr  = addr_of(wr_layer, wr_row);
    assign upd_addr = addr_of(upd_layer, upd_row);
    assign rd_addr  = addr_of(rd_layer, rd_row);

    // A same-row host write overrides the gradient step entirely
    assign wr_ok      = wr_fire && wr_inr;
    assign upd_commit = upd_fire && upd_inr
                        && !(wr_ok && (wr_addr == upd_addr));

    assign upd_cur = upd_inr ? mem_q[upd_addr] : '0;
    assign rd_word = rd_inr ? mem_q[rd_addr] : '0;

    weight_update_alu #(
        .COLS     (COLS),
        .LR_SHIFT (LR_SHIFT)
    ) u_alu (
        .row_i  (upd_cur),
        .grad_i (upd_grad),
        .row_o  (upd_new),
        .sat_o  (upd_sat)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            CLEAR: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        sat_add = '0;
        for (int c = 0; c < COLS; c++) begin
            if (upd_commit && upd_sat[c]) begin
                sat_add = sat_add + {{SATCNT_W{1'b0}}, 1'b1};
            end
        end
        sat_sum = {1'b0, sat_q} + sat_add;
        sat_d   = sat_sum[SATCNT_W] ? '1 : sat_sum[SATCNT_W-1:0];
    end

    assign err_d = (wr_fire && !wr_inr)
                || (upd_fire && !upd_inr)
                || (rd_fire && !rd_inr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= CLEAR;
            idx_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            sat_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rd_valid_q <= rd_fire;
            sat_q      <= sat_d;
            err_q      <= err_d;
            if (rd_fire) begin
                rd_data_q <= rd_word;
            end
        end
    end

    // Storage has no reset; the sweep is what initialises it
    always_ff @(posedge clk) begin
        if (busy) begin
            mem_q[idx_q] <= '0;
        end else begin
            if (upd_commit) begin
                mem_q[upd_addr] <= upd_new;
            end
            if (wr_ok) begin
                mem_q[wr_addr] <= wr_data;
            end
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign sat_count = sat_q;
    assign err_oob   = err_q;

endmodule

// File: tb/tb_weight_bank.sv
// Self-checking bench for weight_bank: directed steps plus random traffic
// compared against an integer-arithmetic model of the weight array.
module tb_weight_bank;

    localparam int L  = 5;
    localparam int R  = 3;
    localparam int C  = 3;
    localparam int DW = 16;
    localparam int LR = 0;
    localparam int NROWS = L * R;
    localparam int SATMAX = 65535;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear_req;
    logic          busy;
    logic          upd_valid;
    logic          upd_ready;
    logic [2:0]    upd_layer;
    logic [1:0]    upd_row;
    logic [47:0]   upd_grad;
    logic          wr_valid;
    logic          wr_ready;
    logic [2:0]    wr_layer;
    logic [1:0]    wr_row;
    logic [47:0]   wr_data;
    logic          rd_en;
    logic [2:0]    rd_layer;
    logic [1:0]    rd_row;
    logic [47:0]   rd_data;
    logic          rd_valid;
    logic [15:0]   sat_count;
    logic          err_oob;

    weight_bank dut (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .busy      (busy),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .upd_layer (upd_layer),
        .upd_row   (upd_row),
        .upd_grad  (upd_grad),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_layer  (wr_layer),
        .wr_row    (wr_row),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_layer  (rd_layer),
        .rd_row    (rd_row),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .sat_count (sat_count),
        .err_oob   (err_oob)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int          mw [L][R][C];
    int          msat;
    logic [47:0] exp_rd;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [47:0] pack3(input int a, input int b,
                                          input int c);
        logic [47:0] v;
        v = {16'(a), 16'(b), 16'(c)};
        return v;
    endfunction

    function automatic logic [47:0] model_row(input int l, input int r);
        return pack3(mw[l][r][0], mw[l][r][1], mw[l][r][2]);
    endfunction

    function automatic int col_of(input logic [47:0] v, input int c);
        logic signed [15:0] s;
        s = v[(C-1-c)*DW +: DW];
        return int'(s);
    endfunction

    function automatic void model_zero();
        for (int l = 0; l < L; l++)
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++)
                    mw[l][r][c] = 0;
    endfunction

    // One IDLE cycle: drive a request set, predict, advance, compare
    task automatic cycle(input string tag,
                         input bit wv, input int wl, input int wrr,
                         input logic [47:0] wd,
                         input bit uv, input int ul, input int ur,
                         input logic [47:0] ug,
                         input bit rv, input int rl, input int rr);
        bit w_in, u_in, r_in, e_err;
        int w, g, d;
        w_in = (wl < L) && (wrr < R);
        u_in = (ul < L) && (ur < R);
        r_in = (rl < L) && (rr < R);
        wr_valid  = wv;  wr_layer = 3'(wl); wr_row = 2'(wrr);
        wr_data   = wd;
        upd_valid = uv;  upd_layer = 3'(ul); upd_row = 2'(ur);
        upd_grad  = ug;
        rd_en     = rv;  rd_layer = 3'(rl); rd_row = 2'(rr);
        e_err = (wv && !w_in) || (uv && !u_in) || (rv && !r_in);
        if (rv) exp_rd = r_in ? model_row(rl, rr) : 48'h0;
        if (uv && u_in && !(wv && w_in && wl == ul && wrr == ur)) begin
            for (int c = 0; c < C; c++) begin
                w = mw[ul][ur][c];
                g = col_of(ug, c) >>> LR;
                d = w - g;
                if (d > 32767 || d < -32768) begin
                    d = (d > 0) ? 32767 : -32768;
                    msat = (msat < SATMAX) ? msat + 1 : SATMAX;
                end
                mw[ul][ur][c] = d;
            end
        end
        if (wv && w_in)
            for (int c = 0; c < C; c++) mw[wl][wrr][c] = col_of(wd, c);
        tick();
        wr_valid = 0; upd_valid = 0; rd_en = 0;
        chk({tag, "_rv"}, 64'(rd_valid), 64'(rv));
        chk({tag, "_rd"}, 64'(rd_data), 64'(exp_rd));
        chk({tag, "_err"}, 64'(err_oob), 64'(e_err));
        chk({tag, "_sat"}, 64'(sat_count), 64'(msat));
    endtask

    task automatic rd(input string tag, input int l, input int r);
        cycle(tag, 0, 0, 0, 48'h0, 0, 0, 0, 48'h0, 1, l, r);
    endtask

    // Count busy cycles while hammering the ports that must be ignored
    task automatic count_busy(input string tag);
        int cnt;
        bit leak;
        cnt = 0;
        leak = 0;
        rd_en = 1; rd_layer = 0; rd_row = 0;
        wr_valid = 1; wr_layer = 0; wr_row = 0; wr_data = '1;
        upd_valid = 1; upd_layer = 0; upd_row = 0; upd_grad = 48'h1;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            if (rd_valid || upd_ready || wr_ready) leak = 1;
            cnt++;
            tick();
        end
        rd_en = 0; wr_valid = 0; upd_valid = 0;
        chk({tag, "_busycnt"}, 64'(cnt), 64'(NROWS));
        chk({tag, "_ignored"}, 64'(leak), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] d0, d1;
        int          l, r, l2, r2;
        bit          wv, uv, rv;
        reset = 1; clear_req = 0;
        upd_valid = 0; upd_layer = 0; upd_row = 0; upd_grad = 0;
        wr_valid = 0; wr_layer = 0; wr_row = 0; wr_data = 0;
        rd_en = 0; rd_layer = 0; rd_row = 0;
        model_zero();
        msat = 0;
        exp_rd = 0;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'(1));
        chk("rst_rv", 64'(rd_valid), 64'(0));
        chk("rst_rd", 64'(rd_data), 64'(0));
        chk("rst_sat", 64'(sat_count), 64'(0));
        chk("rst_err", 64'(err_oob), 64'(0));
        reset = 0;
        count_busy("sweep0");

        for (int i = 0; i < NROWS; i++) rd("init", i / R, i % R);
        cycle("hold", 0, 0, 0, 48'h0, 0, 0, 0, 48'h0, 0, 0, 0);

        cycle("wr21", 1, 2, 1, 48'h0100_FF00_0080, 0, 0, 0, 48'h0,
              0, 0, 0);
        rd("rd21", 2, 1);
        chk("rd21_lit", 64'(rd_data), 64'h0100_FF00_0080);
        cycle("rdw", 1, 3, 0, 48'h1234_5678_9ABC, 0, 0, 0, 48'h0,
              1, 3, 0);
        chk("rdw_old", 64'(rd_data), 64'h0);
        rd("rdw_new", 3, 0);

        cycle("wr10", 1, 1, 0, 48'h7F00_0100_0000, 0, 0, 0, 48'h0,
              0, 0, 0);
        cycle("upd10", 0, 0, 0, 48'h0, 1, 1, 0, 48'h8000_0080_0000,
              0, 0, 0);
        rd("rd10", 1, 0);
        chk("sat_lit", 64'(rd_data), 64'h7FFF_0080_0000);
        chk("satcnt_lit", 64'(sat_count), 64'(1));

        cycle("wu_same", 1, 0, 0, 48'h0001_0001_0001, 1, 0, 0,
              48'h8000_8000_8000, 0, 0, 0);
        rd("rd00", 0, 0);
        chk("wu_same_lit", 64'(rd_data), 64'h0001_0001_0001);
        cycle("wu_diff", 1, 0, 0, 48'h0005_0005_0005, 1, 0, 1,
              48'h0010_FFF0_0000, 0, 0, 0);
        rd("rd00b", 0, 0);
        rd("rd01", 0, 1);
        chk("wu_diff_lit", 64'(rd_data), 64'hFFF0_0010_0000);

        cycle("oob_upd", 0, 0, 0, 48'h0, 1, 5, 0, 48'h0001_0001_0001,
              0, 0, 0);
        cycle("oob_idle", 0, 0, 0, 48'h0, 0, 0, 0, 48'h0, 0, 0, 0);
        rd("oob_chk", 0, 0);
        rd("oob_rd", 7, 0);
        chk("oob_rd_lit", 64'(rd_data), 64'h0);

        for (int i = 0; i < 400; i++) begin
            wv = ($urandom % 2) == 1;
            uv = ($urandom % 3) == 0;
            rv = ($urandom % 2) == 1;
            l  = ($urandom % 16 == 0) ? $urandom_range(5, 7) : $urandom % L;
            r  = ($urandom % 16 == 0) ? 3 : $urandom % R;
            l2 = ($urandom % 16 == 0) ? $urandom_range(5, 7) : $urandom % L;
            r2 = ($urandom % 16 == 0) ? 3 : $urandom % R;
            d0 = {16'($urandom), 16'($urandom), 16'($urandom)};
            if ($urandom % 4 == 0)
                d1 = {16'($urandom), 16'($urandom), 16'($urandom)};
            else
                d1 = {16'($urandom_range(0, 1023) - 512),
                      16'($urandom_range(0, 1023) - 512),
                      16'($urandom_range(0, 1023) - 512)};
            cycle("rnd", wv, l, r, d0, uv, l2, r2, d1, rv,
                  $urandom % 8, $urandom % 4);
        end

        clear_req = 1;
        tick();
        clear_req = 0;
        count_busy("clr");
        model_zero();
        for (int i = 0; i < NROWS; i++) rd("clr_rd", i / R, i % R);

        cycle("pre", 1, 4, 2, 48'hAAAA_5555_0F0F, 0, 0, 0, 48'h0, 1, 2, 1);
        clear_req = 1;
        tick();
        clear_req = 0;
        repeat (7) tick();
        reset = 1;
        #1;
        msat = 0;
        exp_rd = 0;
        chk("mid_busy", 64'(busy), 64'(1));
        chk("mid_sat", 64'(sat_count), 64'(0));
        chk("mid_rd", 64'(rd_data), 64'(0));
        tick();
        reset = 0;
        count_busy("mid");
        model_zero();
        for (int i = 0; i < NROWS; i++) rd("mid_rd", i / R, i % R);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
